// File: rtl/instruction_loader_if.sv
// Host-to-loader word handshake plus the loader's byte write port and status.
// The loader (slave) drives the memory port and status; the host (master) supplies words.
interface instruction_loader_if #(
  parameter int ADDR_W = 8
);
  logic              Start;
  logic [31:0]       WordIn;
  logic              WordValid;
  logic              LastWord;
  logic              WordReady;
  logic              MemWE;
  logic [ADDR_W-1:0] MemAddr;
  logic [7:0]        MemByte;
  logic              Busy;
  logic              Done;
  logic              Overflow;
  logic [7:0]        Checksum;

  modport master (
    output Start, WordIn, WordValid, LastWord,
    input  WordReady, MemWE, MemAddr, MemByte, Busy, Done, Overflow, Checksum
  );

  modport slave (
    input  Start, WordIn, WordValid, LastWord,
    output WordReady, MemWE, MemAddr, MemByte, Busy, Done, Overflow, Checksum
  );
endinterface

// File: rtl/instruction_loader.sv
// Serialises 32-bit instruction words into four big-endian byte writes (MSB first).
// Optional running byte checksum is built only when LOADER_CHECKSUM_EN is defined.
module instruction_loader #(
  parameter int ADDR_W      = 8,
  parameter int DEPTH_BYTES = 256,
  parameter int START_ADDR  = 0
) (
  input  logic                 CLK,
  input  logic                 Reset,
  instruction_loader_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_DONE
  } state_t;

  // One extra bit so base+3 at the top of memory cannot alias to a low address.
  localparam logic [ADDR_W:0] LP_START     = (ADDR_W+1)'(START_ADDR);
  localparam logic [ADDR_W:0] LP_LAST_ADDR = (ADDR_W+1)'(DEPTH_BYTES - 1);
  localparam logic [ADDR_W:0] LP_THREE     = (ADDR_W+1)'(3);
  localparam logic [ADDR_W:0] LP_FOUR      = (ADDR_W+1)'(4);

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W:0]   r_base;
  logic [31:0]       r_word;
  logic              r_last;
  logic [1:0]        r_beat;
  logic              r_overflow;
  logic              w_start_ok;
  logic              w_fits;
  logic [7:0]        w_byte;
  logic [ADDR_W-1:0] w_addr;

  assign w_start_ok = ((r_state == S_IDLE) || (r_state == S_DONE)) && bus.Start;
  assign w_fits     = (r_base + LP_THREE) <= LP_LAST_ADDR;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: if (bus.Start) w_next_state = S_ACCEPT;
      S_ACCEPT:       if (bus.WordValid) w_next_state = w_fits ? S_WRITE : S_DONE;
      S_WRITE:        if (r_beat == 2'd3) w_next_state = r_last ? S_DONE : S_ACCEPT;
      default:        w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_base     <= '0;
      r_word     <= '0;
      r_last     <= 1'b0;
      r_beat     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_next_state;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.Start) begin
            r_base     <= LP_START;
            r_overflow <= 1'b0;
          end
        end
        S_ACCEPT: begin
          if (bus.WordValid) begin
            if (w_fits) begin
              r_word <= bus.WordIn;
              r_last <= bus.LastWord;
              r_beat <= 2'd0;
            end else begin
              r_overflow <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          r_beat <= r_beat + 2'd1;
          if (r_beat == 2'd3) r_base <= r_base + LP_FOUR;
        end
        default: ;
      endcase
    end
  end

  // Address and data are forced to zero outside WRITE so the port is quiet when idle.
  always_comb begin
    w_byte = 8'h00;
    w_addr = '0;
    if (r_state == S_WRITE) begin
      w_addr = r_base[ADDR_W-1:0] + ADDR_W'(r_beat);
      unique case (r_beat)
        2'd0:    w_byte = r_word[31:24];
        2'd1:    w_byte = r_word[23:16];
        2'd2:    w_byte = r_word[15:8];
        default: w_byte = r_word[7:0];
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_checksum;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_checksum <= 8'h00;
    end else if (w_start_ok) begin
      r_checksum <= 8'h00;
    end else if (r_state == S_WRITE) begin
      r_checksum <= r_checksum + w_byte;
    end
  end

  assign bus.Checksum = r_checksum;
`else
  assign bus.Checksum = 8'h00;
`endif

  assign bus.WordReady = (r_state == S_ACCEPT);
  assign bus.Busy      = (r_state == S_ACCEPT) || (r_state == S_WRITE);
  assign bus.MemWE     = (r_state == S_WRITE);
  assign bus.MemAddr   = w_addr;
  assign bus.MemByte   = w_byte;
  assign bus.Done      = (r_state == S_DONE);
  assign bus.Overflow  = r_overflow;

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench: a 256-byte and an 8-byte loader driven with directed and random loads.
// Expected writes come from a byte-address model (base, running sum) kept in the bench.
module tb_instruction_loader;

  localparam int ADDR_W = 8;
  localparam int START  = 0;
  localparam int DEPTH0 = 256;
  localparam int DEPTH1 = 8;

  logic CLK   = 1'b0;
  logic Reset = 1'b1;
  always #5 CLK = ~CLK;

  instruction_loader_if #(.ADDR_W(ADDR_W)) bus0 ();
  instruction_loader_if #(.ADDR_W(ADDR_W)) bus1 ();

  instruction_loader #(.ADDR_W(ADDR_W), .DEPTH_BYTES(DEPTH0), .START_ADDR(START)) u_dut0 (
    .CLK(CLK), .Reset(Reset), .bus(bus0)
  );
  instruction_loader #(.ADDR_W(ADDR_W), .DEPTH_BYTES(DEPTH1), .START_ADDR(START)) u_dut1 (
    .CLK(CLK), .Reset(Reset), .bus(bus1)
  );

  logic        start_q [2];
  logic [31:0] word_q  [2];
  logic        valid_q [2];
  logic        last_q  [2];

  assign bus0.Start = start_q[0];  assign bus1.Start = start_q[1];
  assign bus0.WordIn = word_q[0];  assign bus1.WordIn = word_q[1];
  assign bus0.WordValid = valid_q[0];  assign bus1.WordValid = valid_q[1];
  assign bus0.LastWord = last_q[0];  assign bus1.LastWord = last_q[1];

  logic       ready_o [2];
  logic       we_o    [2];
  logic       busy_o  [2];
  logic       done_o  [2];
  logic       ovf_o   [2];
  logic [7:0] addr_o  [2];
  logic [7:0] byte_o  [2];
  logic [7:0] sum_o   [2];

  assign ready_o[0] = bus0.WordReady;  assign ready_o[1] = bus1.WordReady;
  assign we_o[0]    = bus0.MemWE;      assign we_o[1]    = bus1.MemWE;
  assign busy_o[0]  = bus0.Busy;       assign busy_o[1]  = bus1.Busy;
  assign done_o[0]  = bus0.Done;       assign done_o[1]  = bus1.Done;
  assign ovf_o[0]   = bus0.Overflow;   assign ovf_o[1]   = bus1.Overflow;
  assign addr_o[0]  = bus0.MemAddr;    assign addr_o[1]  = bus1.MemAddr;
  assign byte_o[0]  = bus0.MemByte;    assign byte_o[1]  = bus1.MemByte;
  assign sum_o[0]   = bus0.Checksum;   assign sum_o[1]   = bus1.Checksum;

  int n_cmp = 0;
  int n_bad = 0;
  int m_base [2];
  int m_sum  [2];
  int bad_wr [2] = '{0, 0};

  // Any write outside the memory is an error regardless of what the bench is doing.
  always @(negedge CLK) begin
    if (we_o[0] === 1'b1 && int'(addr_o[0]) >= DEPTH0) bad_wr[0] <= bad_wr[0] + 1;
    if (we_o[1] === 1'b1 && int'(addr_o[1]) >= DEPTH1) bad_wr[1] <= bad_wr[1] + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int depth(input int d);
    return (d == 0) ? DEPTH0 : DEPTH1;
  endfunction

  function automatic logic [7:0] exp_sum(input int d);
`ifdef LOADER_CHECKSUM_EN
    return 8'(m_sum[d]);
`else
    return 8'h00;
`endif
  endfunction

  // Called at a negedge with the loader in IDLE or DONE.
  task automatic do_start(input int d);
    start_q[d] = 1'b1;
    @(negedge CLK);
    start_q[d] = 1'b0;
    m_base[d]  = START;
    m_sum[d]   = 0;
    check("start_ready", ready_o[d], 1);
    check("start_busy",  busy_o[d], 1);
    check("start_done",  done_o[d], 0);
    check("start_ovf",   ovf_o[d], 0);
    check("start_sum",   sum_o[d], 0);
    check("start_we",    we_o[d], 0);
  endtask

  task automatic send_word(input int d, input logic [31:0] w, input logic last,
                           input int gap, input bit poke_start, output bit finished);
    int         waited;
    bit         fits;
    logic [7:0] b;
    finished = 1'b0;
    if (gap > 0) begin
      valid_q[d] = 1'b0;
      repeat (gap) begin
        @(negedge CLK);
        check("gap_no_we", we_o[d], 0);
      end
    end
    valid_q[d] = 1'b1;
    word_q[d]  = w;
    last_q[d]  = last;
    waited     = 0;
    while (ready_o[d] !== 1'b1 && waited < 20) begin
      @(negedge CLK);
      waited++;
    end
    check("accept_latency", waited, 0);
    if (ready_o[d] !== 1'b1) begin
      finished = 1'b1;
      return;
    end
    fits = (m_base[d] + 3) <= (depth(d) - 1);
    @(negedge CLK);
    if (fits) begin
      for (int i = 0; i < 4; i++) begin
        b = w[31-8*i -: 8];
        check("we",       we_o[d], 1);
        check("addr",     addr_o[d], m_base[d] + i);
        check("byte",     byte_o[d], b);
        check("busy_wr",  busy_o[d], 1);
        check("ready_wr", ready_o[d], 0);
        check("sum_wr",   sum_o[d], exp_sum(d));
        m_sum[d] += int'(b);
        if (poke_start && i == 1) start_q[d] = 1'b1;
        @(negedge CLK);
        start_q[d] = 1'b0;
      end
      m_base[d] += 4;
      if (last) begin
        check("done",      done_o[d], 1);
        check("busy_done", busy_o[d], 0);
        check("we_done",   we_o[d], 0);
        check("ovf_clear", ovf_o[d], 0);
        check("sum_done",  sum_o[d], exp_sum(d));
        finished = 1'b1;
      end else begin
        check("ready_next", ready_o[d], 1);
      end
    end else begin
      check("ovf",       ovf_o[d], 1);
      check("ovf_done",  done_o[d], 1);
      check("ovf_we",    we_o[d], 0);
      check("ovf_busy",  busy_o[d], 0);
      check("ovf_ready", ready_o[d], 0);
      finished = 1'b1;
    end
  endtask

  task automatic load_words(input int d, input logic [31:0] words[$], input int max_gap,
                            input bit pokes);
    bit fin;
    do_start(d);
    for (int i = 0; i < words.size(); i++) begin
      send_word(d, words[i], logic'(i == words.size() - 1), $urandom_range(max_gap, 0),
                pokes && ($urandom_range(1, 0) == 1), fin);
      if (fin) break;
    end
    valid_q[d] = 1'b0;
    last_q[d]  = 1'b0;
    repeat (2) @(negedge CLK);
    check("done_hold",  done_o[d], 1);
    check("ready_hold", ready_o[d], 0);
    check("sum_hold",   sum_o[d], exp_sum(d));
  endtask

  initial begin
    logic [31:0] q[$];
    for (int d = 0; d < 2; d++) begin
      start_q[d] = 1'b0; word_q[d] = '0; valid_q[d] = 1'b0; last_q[d] = 1'b0;
      m_base[d] = START; m_sum[d] = 0;
    end

    // Reset held, then released: everything quiet until Start.
    repeat (3) @(negedge CLK);
    for (int d = 0; d < 2; d++) begin
      check("rst_ready", ready_o[d], 0);
      check("rst_we",    we_o[d], 0);
      check("rst_busy",  busy_o[d], 0);
      check("rst_done",  done_o[d], 0);
      check("rst_ovf",   ovf_o[d], 0);
      check("rst_addr",  addr_o[d], 0);
      check("rst_byte",  byte_o[d], 0);
      check("rst_sum",   sum_o[d], 0);
    end
    Reset = 1'b0;
    repeat (3) @(negedge CLK);
    check("idle_ready", ready_o[0], 0);
    check("idle_busy",  busy_o[0], 0);

    // Single word, then three words with WordValid held high.
    q = '{32'h8C01_0004};
    load_words(0, q, 0, 1'b0);
    q = '{32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC};
    load_words(0, q, 0, 1'b0);

    // Small memory: third word cannot fit and is dropped.
    q = '{32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0BAD_C0DE};
    load_words(1, q, 0, 1'b0);
    check("ovf_sticky", ovf_o[1], 1);

    // Asynchronous reset during beat 2 of a word.
    do_start(0);
    valid_q[0] = 1'b1; word_q[0] = 32'hA1B2_C3D4; last_q[0] = 1'b1;
    repeat (3) @(negedge CLK);
    check("pre_rst_addr", addr_o[0], 2);
    check("pre_rst_we",   we_o[0], 1);
    #2 Reset = 1'b1;
    #1;
    check("async_we",    we_o[0], 0);
    check("async_busy",  busy_o[0], 0);
    check("async_ready", ready_o[0], 0);
    @(negedge CLK);
    Reset = 1'b0;
    valid_q[0] = 1'b0;
    @(negedge CLK);
    check("post_rst_busy", busy_o[0], 0);
    q = '{32'h0102_0304};
    load_words(0, q, 0, 1'b0);
    check("cksum_0102_0304", sum_o[0], exp_sum(0));

    // Random loads with random gaps and stray Start pulses during writes.
    for (int n = 0; n < 20; n++) begin
      q = {};
      for (int k = 0; k < $urandom_range(6, 1); k++) q.push_back($urandom);
      load_words(0, q, 2, 1'b1);
    end
    for (int n = 0; n < 6; n++) begin
      q = {};
      for (int k = 0; k < $urandom_range(3, 1); k++) q.push_back($urandom);
      load_words(1, q, 2, 1'b1);
    end

    // Fill the full 256-byte memory; the 65th word lands at the top boundary and is dropped.
    q = {};
    for (int k = 0; k < 65; k++) q.push_back($urandom);
    load_words(0, q, 0, 1'b0);
    check("full_ovf", ovf_o[0], 1);

    check("no_oob_write0", bad_wr[0], 0);
    check("no_oob_write1", bad_wr[1], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
